// File: rtl/alarm_bist_ctrl.sv
// Self-test sequencer and input arbiter for the 5-input alarm circuit.
// Passes sensor inputs through in functional mode; sweeps all 32 vectors on start.
module alarm_bist_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter logic [31:0] GOLDEN = 32'hB32D224C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] func_x,
    output logic [4:0] dut_x,
    input  logic       dut_y,
    output logic       alarm,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_count,
    output logic [4:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

    localparam logic [3:0] WcntLoad = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [4:0] vec_q, vec_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [4:0] dut_x_q, dut_x_d;
    logic       alarm_q, alarm_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [5:0] fail_count_q, fail_count_d;
    logic [4:0] first_fail_q, first_fail_d;
    logic       fail_valid_q, fail_valid_d;

    logic       mismatch;
    logic [5:0] count_nxt;

    assign mismatch  = (dut_y != GOLDEN[vec_q]);
    assign count_nxt = fail_count_q + {5'd0, mismatch};

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        wcnt_d       = wcnt_q;
        dut_x_d      = dut_x_q;
        alarm_d      = alarm_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;

        unique case (state_q)
            StIdle: begin
                dut_x_d = func_x;
                alarm_d = dut_y;
                if (start) begin
                    state_d      = StWait;
                    vec_d        = 5'd0;
                    dut_x_d      = 5'd0;
                    wcnt_d       = WcntLoad;
                    pass_d       = 1'b0;
                    fail_count_d = 6'd0;
                    first_fail_d = 5'd0;
                    fail_valid_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            StWait: begin
                if (wcnt_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            StCheck: begin
                fail_count_d = count_nxt;
                if (mismatch && !fail_valid_q) begin
                    first_fail_d = vec_q;
                    fail_valid_d = 1'b1;
                end
                if (vec_q == 5'd31) begin
                    // Verdict uses the count including this final check
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (count_nxt == 6'd0);
                end else begin
                    state_d = StWait;
                    vec_d   = vec_q + 5'd1;
                    dut_x_d = vec_q + 5'd1;
                    wcnt_d  = WcntLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
                dut_x_d = func_x;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vec_q        <= 5'd0;
            wcnt_q       <= 4'd0;
            dut_x_q      <= 5'd0;
            alarm_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 6'd0;
            first_fail_q <= 5'd0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            wcnt_q       <= wcnt_d;
            dut_x_q      <= dut_x_d;
            alarm_q      <= alarm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    assign dut_x      = dut_x_q;
    assign alarm      = alarm_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;
    assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_alarm_bist_ctrl.sv
// Directed self-checking bench for alarm_bist_ctrl with a behavioural alarm circuit
// whose output can be forced stuck or faulted at vector 31.
module tb_alarm_bist_ctrl;

    localparam logic [31:0] TRUTH = 32'hB32D224C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] func_x;
    logic [4:0] dut_x;
    logic       dut_y;
    logic       alarm, busy, done, pass, fail_valid;
    logic [5:0] fail_count;
    logic [4:0] first_fail;

    int mode;  // 0 golden, 1 stuck-0, 2 stuck-1, 3 vector 31 inverted
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic model_y(input logic [4:0] x, input int m);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return TRUTH[x] ^ (x == 5'd31);
            default: return TRUTH[x];
        endcase
    endfunction

    assign dut_y = model_y(dut_x, mode);

    alarm_bist_ctrl #(.SETTLE(2), .GOLDEN(32'hB32D224C)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .func_x     (func_x),
        .dut_x      (dut_x),
        .dut_y      (dut_y),
        .alarm      (alarm),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ticks until done is seen; lat counts edges after the start edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    // Start pulse, wait for done, then step back into IDLE.
    task automatic run_sweep(input int m, output int lat);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({dut_x, alarm, busy, done, pass, fail_count, first_fail, fail_valid} !== 21'd0)
            $display("FAIL reset_outputs: got dut_x=%0d alarm=%b busy=%b done=%b pass=%b cnt=%0d ff=%0d fv=%b want all 0",
                     dut_x, alarm, busy, done, pass, fail_count, first_fail, fail_valid);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_functional;
        func_x = 5'b10000;
        tick();
        n_checks++;
        if (dut_x !== 5'd16) $display("FAIL func_dut_x_16: got %0d want 16", dut_x);
        else n_pass++;
        tick();
        n_checks++;
        if (alarm !== 1'b1) $display("FAIL func_alarm_16: got %b want 1", alarm);
        else n_pass++;
        func_x = 5'b00111;
        tick();
        tick();
        n_checks++;
        if (dut_x !== 5'd7) $display("FAIL func_dut_x_7: got %0d want 7", dut_x);
        else n_pass++;
        n_checks++;
        if (alarm !== 1'b0) $display("FAIL func_alarm_7: got %b want 0", alarm);
        else n_pass++;
    endtask

    task automatic test_golden_sweep;
        int lat;
        int errs;
        mode   = 0;
        func_x = 5'd16;
        tick();
        tick();  // alarm now 1, must stay frozen through the sweep
        start = 1'b1;
        tick();
        start  = 1'b0;
        func_x = 5'd7;
        lat    = 0;
        errs   = 0;
        while (done !== 1'b1 && lat < 300) begin
            if (dut_x !== 5'(lat / 3) || busy !== 1'b1 || alarm !== 1'b1) errs++;
            tick();
            lat++;
        end
        n_checks++;
        if (lat != 96) $display("FAIL golden_latency: got %0d want 96", lat);
        else n_pass++;
        n_checks++;
        if (errs != 0) $display("FAIL golden_pacing_busy_alarm: got %0d bad cycles want 0", errs);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL golden_busy_in_done: got %b want 0", busy);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL golden_done_pulse: got %b want 0", done);
        else n_pass++;
        n_checks++;
        if (dut_x !== 5'd7) $display("FAIL golden_func_resume: got %0d want 7", dut_x);
        else n_pass++;
        n_checks++;
        if ({pass, fail_count, fail_valid} !== {1'b1, 6'd0, 1'b0})
            $display("FAIL golden_result: got pass=%b cnt=%0d fv=%b want 1/0/0",
                     pass, fail_count, fail_valid);
        else n_pass++;
    endtask

    task automatic test_stuck0;
        int lat;
        run_sweep(1, lat);
        n_checks++;
        if ({pass, fail_count, first_fail, fail_valid} !== {1'b0, 6'd14, 5'd2, 1'b1})
            $display("FAIL stuck0_result: got pass=%b cnt=%0d ff=%0d fv=%b want 0/14/2/1",
                     pass, fail_count, first_fail, fail_valid);
        else n_pass++;
    endtask

    task automatic test_stuck1;
        int lat;
        run_sweep(2, lat);
        n_checks++;
        if ({pass, fail_count, first_fail, fail_valid} !== {1'b0, 6'd18, 5'd0, 1'b1})
            $display("FAIL stuck1_result: got pass=%b cnt=%0d ff=%0d fv=%b want 0/18/0/1",
                     pass, fail_count, first_fail, fail_valid);
        else n_pass++;
    endtask

    task automatic test_vec31_then_golden;
        int lat;
        run_sweep(3, lat);
        n_checks++;
        if ({pass, fail_count, first_fail, fail_valid} !== {1'b0, 6'd1, 5'd31, 1'b1})
            $display("FAIL vec31_result: got pass=%b cnt=%0d ff=%0d fv=%b want 0/1/31/1",
                     pass, fail_count, first_fail, fail_valid);
        else n_pass++;
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, pass, fail_count, first_fail, fail_valid} !== {1'b1, 13'd0})
            $display("FAIL rerun_cleared: got busy=%b pass=%b cnt=%0d ff=%0d fv=%b want 1/0/0/0/0",
                     busy, pass, fail_count, first_fail, fail_valid);
        else n_pass++;
        wait_done(lat);
        tick();
        n_checks++;
        if ({pass, fail_count, fail_valid} !== {1'b1, 6'd0, 1'b0})
            $display("FAIL rerun_result: got pass=%b cnt=%0d fv=%b want 1/0/0",
                     pass, fail_count, fail_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        mode  = 0;
        start = 1'b1;
        tick();
        wait_done(lat);
        n_checks++;
        if (lat != 96) $display("FAIL held_latency: got %0d want 96", lat);
        else n_pass++;
        tick();  // DONE -> IDLE; start must not be taken in DONE
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL held_idle_gap: got busy=%b done=%b want 0/0", busy, done);
        else n_pass++;
        tick();  // first IDLE cycle accepts the held start
        n_checks++;
        if ({busy, dut_x} !== {1'b1, 5'd0}) $display("FAIL held_restart: got busy=%b dut_x=%0d want 1/0", busy, dut_x);
        else n_pass++;
        start = 1'b0;
        wait_done(lat);
        tick();
        n_checks++;
        if (lat != 96 || pass !== 1'b1) $display("FAIL held_second_sweep: got lat=%0d pass=%b want 96/1", lat, pass);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep;
        int lat;
        int guard;
        mode   = 1;  // accumulate failures so a retained partial count would show
        func_x = 5'd16;
        start  = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (dut_x !== 5'd10 && guard < 300) begin
            tick();
            guard++;
        end
        n_checks++;
        if (dut_x !== 5'd10 || fail_count !== 6'd4)
            $display("FAIL midreset_reach_vec10: got dut_x=%0d cnt=%0d want 10/4", dut_x, fail_count);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({dut_x, alarm, busy, done, pass, fail_count, first_fail, fail_valid} !== 21'd0)
            $display("FAIL midreset_outputs: got dut_x=%0d alarm=%b busy=%b done=%b pass=%b cnt=%0d ff=%0d fv=%b want all 0",
                     dut_x, alarm, busy, done, pass, fail_count, first_fail, fail_valid);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, dut_x} !== {1'b0, 5'd16}) $display("FAIL midreset_idle: got busy=%b dut_x=%0d want 0/16", busy, dut_x);
        else n_pass++;
        run_sweep(0, lat);
        n_checks++;
        if (lat != 96 || {pass, fail_count, fail_valid} !== {1'b1, 6'd0, 1'b0})
            $display("FAIL midreset_fresh_sweep: got lat=%0d pass=%b cnt=%0d fv=%b want 96/1/0/0",
                     lat, pass, fail_count, fail_valid);
        else n_pass++;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        func_x = 5'd0;
        mode   = 0;
        test_reset();
        test_functional();
        test_golden_sweep();
        test_stuck0();
        test_stuck1();
        test_vec31_then_golden();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_bist_ctrl.md
# alarm_bist_ctrl

Self-test sequencer and input arbiter for the 5-input combinational alarm circuit (`y = f(x[4:0])`). In functional mode it passes the sensor inputs to the circuit and registers its output as `alarm`. On `start` it takes over the circuit inputs and sweeps all 32 vectors. After each vector it waits a settle time and compares `y` against a golden truth-table parameter, then reports pass/fail, the fail count and the first failing vector. It sits directly between the sensor inputs and the alarm circuit instance.

## Interface
- `SETTLE`, 2: cycles waited after applying a vector before sampling `dut_y`; legal range 1..15.
- `GOLDEN`, 32'hB32D224C: expected truth table; bit i = expected `y` for `x = i`. The ones are at 2, 3, 6, 9, 13, 16, 18, 19, 21, 24, 25, 28, 29, 31.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a self-test; sampled only in IDLE.
- `func_x`  in  5  functional sensor inputs.
- `dut_x`  out  5  registered drive to circuit inputs `x[4:0]`.
- `dut_y`  in  1  circuit output `y`.
- `alarm`  out  1  registered functional alarm.
- `busy`  out  1  test sweep in progress.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  last sweep had zero mismatches.
- `fail_count`  out  6  mismatches in last sweep, 0..32.
- `first_fail`  out  5  lowest failing vector of last sweep.
- `fail_valid`  out  1  `first_fail` holds a real value.

## Operation
- **Reset:** when `rst_n`=0 at a clock edge, every output and internal register goes to 0 and the state goes to IDLE. This includes reset mid-sweep; no partial result is retained.
- **States:** IDLE, WAIT, CHECK, DONE. Internal registers: `vec` (5 bits) and `wcnt` (4 bits).
- **IDLE:**
  - `dut_x <= func_x` and `alarm <= dut_y` every cycle.
  - If `start`=1: go to WAIT with `vec <= 0`, `dut_x <= 0` and `wcnt <= SETTLE-1`.
  - The same edge clears `pass`, `fail_count`, `first_fail` and `fail_valid`, and sets `busy <= 1`.
- **WAIT:** if `wcnt`==0, go to CHECK; otherwise decrement `wcnt`.
- **CHECK:** compare `dut_y` with `GOLDEN[vec]`.
  - On mismatch: `fail_count <= fail_count+1`. If `fail_valid`=0, also `first_fail <= vec` and `fail_valid <= 1`.
  - If `vec`==31: go to DONE with `busy <= 0` and `done <= 1`.
  - Otherwise: `vec <= vec+1`, `dut_x <= vec+1`, `wcnt <= SETTLE-1`, and return to WAIT.
- **DONE:**
  - `pass` = (`fail_count`==0), computed from the final count including the vector 31 check.
  - `done` drops at the next edge and the state returns to IDLE.
  - `dut_x <= func_x` resumes that same edge.
- **During WAIT/CHECK/DONE:** `alarm` is frozen at its last IDLE value, and `func_x` is ignored.
- **`start` outside IDLE:** ignored. It is not queued.
- **Result hold:** `pass`, `fail_count`, `first_fail` and `fail_valid` hold until the next accepted `start` or reset.
- **Width:** `fail_count` is 6 bits, so a count of 32 cannot overflow and no saturation is needed. `vec` never wraps within a sweep.

## Timing
- **Functional path:** `func_x` at cycle n → `dut_x` at n+1 → `alarm` at n+2.
- **Vector pacing:** each vector occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in CHECK.
- **Sweep latency:** with `start` accepted at edge T, `done`=1 during cycle T+32·(SETTLE+1). For SETTLE=2 that is T+96.
- **`busy`:** high from edge T through the last CHECK cycle; low in DONE.
- **`done`:** high for exactly one cycle.
- **Back-to-back sweeps:** the earliest next `start` is accepted in the first IDLE cycle after DONE.

## Test plan
- Golden behavioural circuit model, SETTLE=2, `start` pulse → `dut_x` steps 0..31 with 3 cycles per value; `done` one cycle at T+96; `pass`=1, `fail_count`=0, `fail_valid`=0.
- `dut_y` stuck at 0 → `fail_count`=14, `first_fail`=2, `fail_valid`=1, `pass`=0.
- `dut_y` stuck at 1 → `fail_count`=18, `first_fail`=0, `pass`=0.
- Model with the output at vector 31 inverted → `fail_count`=1, `first_fail`=31. Follow with a second sweep using the golden model → results cleared at `start`, then `pass`=1.
- Functional mode:
  - `func_x`=5'b10000 → `dut_x`=16 one cycle later, `alarm`=1 two cycles later.
  - `func_x`=5'b00111 → `alarm`=0.
  - `alarm` stays frozen throughout a sweep.
- Stress cases:
  - `start` held high for the whole sweep → only one sweep runs; a new sweep starts the first cycle after DONE.
  - `rst_n`=0 asserted while `vec`=10 → next cycle all outputs 0 and state IDLE; a fresh sweep then completes normally.
